// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   Memory-stage sequencer between execute and the stacked data memory.
//   Takes one op at a time from execute, drives the memory strobes, address
//   and write data, owns the full-descending stack pointer used by
//   PUSH/POP/CALL/RET, returns load/pop results to writeback and issues PC
//   redirects for CALL/RET.
//
//   Optional feature: define MEM_TIMEOUT_EN to enable the ack watchdog
//   (TIMEOUT_CYCLES cycles in REQ without ack -> drop strobes, pulse bus_err).
//   Without it, REQ waits for ack indefinitely and bus_err is tied low.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   ex_valid / ex_ready              op handshake from execute
//   opcode, alu_result, store_data,
//   pc, rd                           op fields, latched on accept
//   mem_read, mem_write, mem_addr,
//   mem_wdata, mem_rdata, mem_ack    data memory interface
//   wb_valid, wb_we, wb_rd, wb_data  one-cycle writeback pulse
//   redir_valid, redir_pc            one-cycle PC redirect pulse
//   sp                               current stack pointer
//   stack_fault                      one-cycle pulse on overflow/underflow
//   bus_err                          one-cycle pulse on ack timeout
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a new op (ex_ready high)
// REQ    | memory strobe asserted, waiting for mem_ack
// DONE   | one cycle: writeback and/or redirect pulse, then IDLE
module mem_stage_ctrl #(
    parameter logic [31:0] STACK_TOP    = 32'd255,
    parameter logic [31:0] STACK_BOTTOM = 32'd192
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [5:0]  opcode,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [31:0] pc,
    input  logic [4:0]  rd,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    output logic [31:0] sp,
    output logic        stack_fault,
    output logic        bus_err
);

    localparam logic [5:0] OP_LW   = 6'b001010;
    localparam logic [5:0] OP_SW   = 6'b001011;
    localparam logic [5:0] OP_CALL = 6'b001101;
    localparam logic [5:0] OP_RET  = 6'b001110;
    localparam logic [5:0] OP_PUSH = 6'b001111;
    localparam logic [5:0] OP_POP  = 6'b010000;

    localparam logic [31:0] SP_EMPTY = STACK_TOP + 32'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [5:0]  op_q;
    logic [31:0] alu_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] sp_q;
    logic [4:0]  rd_q;
    logic        fault_q;
    logic        bus_err_q;

    // decode of the op being offered by execute
    logic in_push_like, in_pop_like, in_mem, accept, fault_now;

    assign in_push_like = (opcode == OP_PUSH) || (opcode == OP_CALL);
    assign in_pop_like  = (opcode == OP_POP)  || (opcode == OP_RET);
    assign in_mem       = in_push_like || in_pop_like ||
                          (opcode == OP_LW) || (opcode == OP_SW);
    assign accept       = ex_valid && (state == S_IDLE);
    assign fault_now    = accept &&
                          ((in_push_like && (sp_q == STACK_BOTTOM)) ||
                           (in_pop_like  && (sp_q == SP_EMPTY)));

    // decode of the latched op
    logic q_push_like, q_pop_like, q_rd_op, q_wr_op, q_call, q_ret, q_load_wb, q_no_wb;

    assign q_call      = (op_q == OP_CALL);
    assign q_ret       = (op_q == OP_RET);
    assign q_push_like = (op_q == OP_PUSH) || q_call;
    assign q_pop_like  = (op_q == OP_POP)  || q_ret;
    assign q_rd_op     = q_pop_like  || (op_q == OP_LW);
    assign q_wr_op     = q_push_like || (op_q == OP_SW);
    assign q_load_wb   = (op_q == OP_LW) || (op_q == OP_POP);
    assign q_no_wb     = q_wr_op || q_ret;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    // terminal count reached on the last allowed REQ cycle; ack in that cycle still wins
    assign tmo_hit = (state == S_REQ) && !mem_ack && (tmo_cnt == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        ex_ready    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        wb_valid    = 1'b0;
        wb_we       = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        redir_valid = 1'b0;
        redir_pc    = '0;

        case (state)
            S_IDLE: begin
                ex_ready = 1'b1;
                if (accept) begin
                    if (fault_now) begin
                        state_nx = S_IDLE;
                    end else if (in_mem) begin
                        state_nx = S_REQ;
                    end else begin
                        state_nx = S_DONE;
                    end
                end
            end
            S_REQ: begin
                mem_read  = q_rd_op;
                mem_write = q_wr_op;
                mem_addr  = addr_q;
                mem_wdata = q_wr_op ? wdata_q : '0;
                if (mem_ack) begin
                    state_nx = S_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nx = S_IDLE;
                end
`endif
            end
            S_DONE: begin
                state_nx = S_IDLE;
                if (!q_no_wb) begin
                    wb_valid = 1'b1;
                    wb_we    = (rd_q != 5'd0);
                    wb_rd    = rd_q;
                    wb_data  = q_load_wb ? rdata_q : alu_q;
                end
                if (q_call || q_ret) begin
                    redir_valid = 1'b1;
                    redir_pc    = q_call ? alu_q : rdata_q;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            alu_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rd_q      <= '0;
            sp_q      <= SP_EMPTY;
            fault_q   <= 1'b0;
            bus_err_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            fault_q   <= fault_now;
            bus_err_q <= 1'b0;

            if (accept && !fault_now) begin
                op_q  <= opcode;
                alu_q <= alu_result;
                rd_q  <= rd;
                // stack ops address relative to sp; LW/SW use the ALU address
                if (in_push_like) begin
                    addr_q <= sp_q - 32'd1;
                end else if (in_pop_like) begin
                    addr_q <= sp_q;
                end else begin
                    addr_q <= alu_result;
                end
                wdata_q <= (opcode == OP_CALL) ? (pc + 32'd1) : store_data;
`ifdef MEM_TIMEOUT_EN
                tmo_cnt <= TMO_LOAD;
`endif
            end

            if (state == S_REQ) begin
                if (mem_ack) begin
                    rdata_q <= mem_rdata;
                    if (q_push_like) begin
                        sp_q <= sp_q - 32'd1;
                    end else if (q_pop_like) begin
                        sp_q <= sp_q + 32'd1;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_hit) begin
                    bus_err_q <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt - 1'b1;
                end
`endif
            end
        end
    end

    assign sp          = sp_q;
    assign stack_fault = fault_q;
`ifdef MEM_TIMEOUT_EN
    assign bus_err     = bus_err_q;
`else
    assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    localparam logic [5:0] OP_LW   = 6'b001010;
    localparam logic [5:0] OP_SW   = 6'b001011;
    localparam logic [5:0] OP_CALL = 6'b001101;
    localparam logic [5:0] OP_RET  = 6'b001110;
    localparam logic [5:0] OP_PUSH = 6'b001111;
    localparam logic [5:0] OP_POP  = 6'b010000;
    localparam logic [31:0] SP_EMPTY = 32'd256;
    localparam logic [31:0] SP_FULL  = 32'd192;
    localparam int TMO = 16;

    localparam int K_MEM = 0, K_WB = 1, K_REDIR = 2, K_FAULT = 3, K_BUSERR = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [5:0]  opcode;
    logic [31:0] alu_result, store_data, pc;
    logic [4:0]  rd;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        redir_valid;
    logic [31:0] redir_pc, sp;
    logic        stack_fault, bus_err;

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .opcode(opcode), .alu_result(alu_result), .store_data(store_data),
        .pc(pc), .rd(rd),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .sp(sp), .stack_fault(stack_fault), .bus_err(bus_err)
    );

    typedef struct {
        int          kind;
        logic        a;     // MEM: is write; WB: we
        logic [31:0] x;     // MEM: addr; WB: data; REDIR: pc
        logic [31:0] y;     // MEM: wdata
        logic [4:0]  r;     // WB: rd
    } ev_t;

    ev_t expq[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic ev_t mk(input int k, input logic a, input logic [31:0] x,
                               input logic [31:0] y, input logic [4:0] r);
        ev_t e;
        e.kind = k; e.a = a; e.x = x; e.y = y; e.r = r;
        return e;
    endfunction

    // background memory contents for never-written words
    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] sp_m = SP_EMPTY;

    function automatic logic [31:0] mget(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    function automatic bit is_mem_op(input logic [5:0] op);
        return op == OP_LW || op == OP_SW || op == OP_CALL || op == OP_RET ||
               op == OP_PUSH || op == OP_POP;
    endfunction

    task automatic predict(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [31:0] pcv, input logic [4:0] rdv);
        case (op)
            OP_LW: begin
                expq.push_back(mk(K_MEM, 1'b0, alu, 0, 0));
                expq.push_back(mk(K_WB, rdv != 0, mget(alu), 0, rdv));
            end
            OP_SW: begin
                expq.push_back(mk(K_MEM, 1'b1, alu, sd, 0));
                model_mem[alu] = sd;
            end
            OP_PUSH, OP_CALL: begin
                if (sp_m == SP_FULL) begin
                    expq.push_back(mk(K_FAULT, 0, 0, 0, 0));
                end else begin
                    logic [31:0] v;
                    v = (op == OP_CALL) ? pcv + 1 : sd;
                    sp_m = sp_m - 1;
                    expq.push_back(mk(K_MEM, 1'b1, sp_m, v, 0));
                    model_mem[sp_m] = v;
                    if (op == OP_CALL) expq.push_back(mk(K_REDIR, 0, alu, 0, 0));
                end
            end
            OP_POP, OP_RET: begin
                if (sp_m == SP_EMPTY) begin
                    expq.push_back(mk(K_FAULT, 0, 0, 0, 0));
                end else begin
                    expq.push_back(mk(K_MEM, 1'b0, sp_m, 0, 0));
                    if (op == OP_POP) expq.push_back(mk(K_WB, rdv != 0, mget(sp_m), 0, rdv));
                    else              expq.push_back(mk(K_REDIR, 0, mget(sp_m), 0, 0));
                    sp_m = sp_m + 1;
                end
            end
            default: expq.push_back(mk(K_WB, rdv != 0, alu, 0, rdv));
        endcase
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] ext_mem [logic [31:0]];
    int forced_delay = -1;
    bit hold_ack = 0;
    bit idle_noise = 0;
    bit busy = 0;
    int wcnt = 0;

    always @(posedge clk) begin
        #1;
        if (mem_read || mem_write) begin
            if (!busy) begin
                busy = 1;
                wcnt = (forced_delay >= 0) ? forced_delay : $urandom_range(0, 3);
            end
            if (!hold_ack && wcnt == 0) begin
                mem_ack = 1'b1;
                if (mem_write) begin
                    ext_mem[mem_addr] = mem_wdata;
                    mem_rdata = $urandom;
                end else begin
                    mem_rdata = ext_mem.exists(mem_addr) ? ext_mem[mem_addr] : init_val(mem_addr);
                end
                busy = 0;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                if (wcnt > 0) wcnt--;
            end
        end else begin
            busy = 0;
            mem_ack = idle_noise && ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit          in_acc = 0;
    ev_t         cur;
    int          acc_len = 0;
    int          last_len = 0;
    bit          prev_ackdone = 0, prev_acc = 0, prev_rst = 0;
    logic        strobe;

    task automatic pop_exp(input string name, output ev_t e, output bit ok);
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s actual=unexpected_event required=none_pending", name);
            ok = 0;
        end else begin
            e = expq.pop_front();
            ok = 1;
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        strobe = mem_read || mem_write;
        if (prev_rst) begin
            chk("strobe_after_rst", strobe, 0);
            chk("wb_after_rst", wb_valid, 0);
            chk("redir_after_rst", redir_valid, 0);
            in_acc = 0;
        end else begin
            if (strobe) begin
                if (!in_acc) begin
                    chk("strobe_latency", prev_acc, 1);
                    pop_exp("access", e, ok);
                    if (ok) begin
                        cur = e;
                        chk("acc_kind", e.kind, K_MEM);
                        chk("acc_is_write", mem_write, e.a);
                        chk("acc_is_read", mem_read, !e.a);
                        chk("acc_addr", mem_addr, e.x);
                        if (e.a) chk("acc_wdata", mem_wdata, e.y);
                    end
                    in_acc = 1;
                    acc_len = 0;
                end else begin
                    chk("acc_hold", {mem_write, mem_read, mem_addr}, {cur.a, !cur.a, cur.x});
                    if (cur.a) chk("acc_hold_wdata", mem_wdata, cur.y);
                end
                acc_len++;
                if (mem_ack) begin
                    in_acc = 0;
                    last_len = acc_len;
                end
            end else if (in_acc) begin
                if (bus_err) chk("timeout_len", acc_len, TMO);
                else chk("strobe_dropped_early", 1, 0);
                in_acc = 0;
            end

            if (wb_valid) begin
                chk("wb_latency", prev_ackdone || prev_acc, 1);
                pop_exp("wb", e, ok);
                if (ok) begin
                    chk("wb_kind", e.kind, K_WB);
                    chk("wb_we", wb_we, e.a);
                    chk("wb_rd", wb_rd, e.r);
                    chk("wb_data", wb_data, e.x);
                end
            end
            if (redir_valid) begin
                chk("redir_latency", prev_ackdone, 1);
                pop_exp("redir", e, ok);
                if (ok) begin
                    chk("redir_kind", e.kind, K_REDIR);
                    chk("redir_pc", redir_pc, e.x);
                end
            end
            if (stack_fault) begin
                chk("fault_latency", prev_acc, 1);
                pop_exp("stack_fault", e, ok);
                if (ok) chk("fault_kind", e.kind, K_FAULT);
            end
            if (bus_err) begin
                pop_exp("bus_err", e, ok);
                if (ok) chk("bus_err_kind", e.kind, K_BUSERR);
            end
        end
        prev_ackdone = strobe && mem_ack;
        prev_acc     = ex_valid && ex_ready;
        prev_rst     = rst;
    end

    // ---------------- driver ----------------
    task automatic wait_ready();
        int g = 0;
        while (!ex_ready) begin
            @(posedge clk); #1;
            g++;
            if (g > 100) begin
                chk("ex_ready_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [31:0] pcv, input logic [4:0] rdv);
        ex_valid = 1'b1; opcode = op; alu_result = alu; store_data = sd; pc = pcv; rd = rdv;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        opcode = $urandom; alu_result = $urandom; store_data = $urandom; pc = $urandom; rd = $urandom;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [31:0] pcv, input logic [4:0] rdv);
        wait_ready();
        chk("sp_before_op", sp, sp_m);
        predict(op, alu, sd, pcv, rdv);
        drive(op, alu, sd, pcv, rdv);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (!(expq.size() == 0 && ex_ready)) begin
            @(posedge clk); #1;
            g++;
            if (g > 200) begin
                chk("drain_timeout", expq.size(), 0);
                expq.delete();
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; opcode = '0; alu_result = '0; store_data = '0;
        pc = '0; rd = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_strobes", {mem_read, mem_write}, 0);
        chk("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
        chk("rst_wb", {wb_valid, wb_we, wb_rd}, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_redir", {redir_valid, redir_pc}, 0);
        chk("rst_sp", sp, SP_EMPTY);
        chk("rst_pulses", {stack_fault, bus_err}, 0);
        rst = 1'b0;

        // store held two cycles, then load it back
        forced_delay = 1;
        issue(OP_SW, 32'd4, 32'h12345678, 32'd100, 5'd7);
        wait_idle();
        chk("sw_write_len", last_len, 2);
        forced_delay = -1;
        issue(OP_LW, 32'd4, 32'h0, 32'd101, 5'd3);
        wait_idle();

        // push / pop round trip
        issue(OP_PUSH, 32'h0, 32'hAABBCCDD, 32'd102, 5'd0);
        wait_idle();
        chk("sp_after_push", sp, 32'd255);
        issue(OP_POP, 32'h0, 32'h0, 32'd103, 5'd1);
        wait_idle();
        chk("sp_after_pop", sp, SP_EMPTY);

        // underflow, fill, overflow, then drain
        issue(OP_POP, 32'h0, 32'h0, 32'd104, 5'd2);
        wait_idle();
        chk("sp_after_underflow", sp, SP_EMPTY);
        for (int i = 0; i < 65; i++) issue(OP_PUSH, 32'h0, $urandom, 32'd200 + i, 5'd0);
        wait_idle();
        chk("sp_full", sp, SP_FULL);
        for (int i = 0; i < 64; i++) issue(OP_POP, 32'h0, 32'h0, 32'd300 + i, 5'($urandom));
        wait_idle();
        chk("sp_drained", sp, SP_EMPTY);

        // call / return
        issue(OP_CALL, 32'd40, 32'h0, 32'd10, 5'd9);
        wait_idle();
        chk("sp_after_call", sp, 32'd255);
        issue(OP_RET, 32'h0, 32'h0, 32'd40, 5'd9);
        wait_idle();
        chk("sp_after_ret", sp, SP_EMPTY);

        // reset in the middle of a load
        hold_ack = 1;
        issue(OP_LW, 32'd8, 32'h0, 32'd500, 5'd2);
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_req_strobe", mem_read, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_drops_strobe", {mem_read, mem_write}, 0);
        chk("rst_mid_sp", sp, SP_EMPTY);
        rst = 1'b0;
        hold_ack = 0;
        expq.delete();
        sp_m = SP_EMPTY;
        repeat (3) begin @(posedge clk); #1; end

        // randomized traffic, with stray acks while idle
        idle_noise = 1;
        for (int i = 0; i < 300; i++) begin
            int          sel;
            logic [5:0]  op;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1: op = OP_LW;
                2, 3: op = OP_SW;
                4, 5: op = OP_PUSH;
                6:    op = OP_POP;
                7:    op = OP_CALL;
                8:    op = OP_RET;
                default: begin
                    op = 6'($urandom);
                    while (is_mem_op(op)) op = 6'($urandom);
                end
            endcase
            if (op == OP_LW || op == OP_SW)
                issue(op, $urandom_range(0, 63), $urandom, $urandom, 5'($urandom));
            else
                issue(op, $urandom, $urandom, $urandom_range(0, 1000), 5'($urandom));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_idle();
        idle_noise = 0;

`ifdef MEM_TIMEOUT_EN
        begin
            int  g;
            bit  seen;
            hold_ack = 1;
            wait_ready();
            expq.push_back(mk(K_MEM, 1'b0, 32'd12, 0, 0));
            expq.push_back(mk(K_BUSERR, 0, 0, 0, 0));
            drive(OP_LW, 32'd12, 32'h0, 32'd600, 5'd4);
            g = 0;
            seen = 0;
            while (!seen && g < 40) begin
                if (bus_err) begin
                    seen = 1;
                    chk("bus_err_ex_ready", ex_ready, 1);
                    chk("bus_err_sp", sp, sp_m);
                end else begin
                    @(posedge clk); #1;
                    g++;
                end
            end
            chk("bus_err_seen", seen, 1);
            hold_ack = 0;
            wait_idle();
        end
`endif

        chk("queue_empty", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
